// File: rtl/aes_req_scheduler.sv
// Round-robin front end that shares one iterative AES-128 core between two requesters.
// One job in flight at a time; a watchdog turns a silent core into an error response.
module aes_req_scheduler #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic [127:0] req1_key,
  output logic         core_start,
  output logic [127:0] core_data,
  output logic [127:0] core_key,
  input  logic         core_done,
  input  logic [127:0] core_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_id,
  output logic         rsp_err,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t       state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic [127:0] core_data_q, core_data_d;
  logic [127:0] core_key_q, core_key_d;
  logic [127:0] rsp_data_q, rsp_data_d;
  logic         rsp_id_q, rsp_id_d;
  logic         rsp_err_q, rsp_err_d;
  logic [7:0]   timer_q, timer_d;

  logic         grant_valid;
  logic         grant_id;

  // Arbitration: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (!reset && state_q == S_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant_q;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign req0_ready = grant_valid && !grant_id;
  assign req1_ready = grant_valid && grant_id;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    core_data_d  = core_data_q;
    core_key_d   = core_key_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    timer_d      = timer_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          core_data_d = grant_id ? req1_data : req0_data;
          core_key_d  = grant_id ? req1_key : req0_key;
          rsp_id_d    = grant_id;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        timer_d = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 8'd1;
        // A done pulse landing on the last timer tick still counts as success.
        if (core_done) begin
          rsp_data_d = core_result;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (timer_q == TIMER_LAST) begin
          rsp_data_d = 128'd0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          last_grant_d = rsp_id_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      core_data_q  <= 128'd0;
      core_key_q   <= 128'd0;
      rsp_data_q   <= 128'd0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      timer_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      core_data_q  <= core_data_d;
      core_key_q   <= core_key_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      timer_q      <= timer_d;
    end
  end

  assign core_start = (state_q == S_LAUNCH);
  assign core_data  = core_data_q;
  assign core_key   = core_key_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Bench for aes_req_scheduler: directed scenarios plus random traffic, checked every cycle
// against a job-level model (one job, arbitration rule, latency arithmetic).
module tb_aes_req_scheduler;

  localparam int TIMEOUT = 16;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0] req0_data, req0_key, req1_data, req1_key;
  logic         core_start, core_done;
  logic [127:0] core_data, core_key, core_result;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [127:0] rsp_data;

  always #5 clk = ~clk;

  aes_req_scheduler #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
    .core_start(core_start), .core_data(core_data), .core_key(core_key),
    .core_done(core_done), .core_result(core_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // job-level reference state
  bit           mdl_busy, mdl_last, job_id, job_err, mdl_rsp_id, mdl_rsp_err;
  int           acc_cyc, resp_cyc;
  logic [127:0] job_data, job_key, job_res, mdl_core_data, mdl_core_key, mdl_rsp_data;

  // core stand-in
  int           core_lat, core_cnt;
  logic [127:0] cm_d, cm_k;
  bit           stray_en, stray_once;

  logic [127:0] d0, k0, d1, k1;
  int           grant_q[$];
  int           rspid_q[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [127:0] mix(input logic [127:0] d, input logic [127:0] k);
    if (d == KAT_PT && k == KAT_KEY) return KAT_CT;
    return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a_3c3c_0f0f_a5a5_1234_5678_9abc_def0;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic mdl_reset();
    mdl_busy = 0; mdl_last = 1; mdl_core_data = '0; mdl_core_key = '0;
    mdl_rsp_data = '0; mdl_rsp_id = 0; mdl_rsp_err = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic run_cycle(input bit v0, input bit v1, input bit rr, input bit rst);
    bit           eg_v, eg_id, exp_rv, exp_re;
    logic [127:0] exp_rd;
    req0_valid = v0; req1_valid = v1; rsp_ready = rr; reset = rst;
    req0_data = d0; req0_key = k0; req1_data = d1; req1_key = k1;
    #1;
    eg_v = 0; eg_id = 0;
    if (!rst && !mdl_busy) begin
      if (v0 && v1) begin eg_v = 1; eg_id = !mdl_last; end
      else if (v0) eg_v = 1;
      else if (v1) begin eg_v = 1; eg_id = 1; end
    end
    exp_rv = mdl_busy && cyc >= resp_cyc;
    exp_rd = exp_rv ? job_res : mdl_rsp_data;
    exp_re = exp_rv ? job_err : mdl_rsp_err;
    chk("req0_ready", 128'(req0_ready), 128'(eg_v && !eg_id));
    chk("req1_ready", 128'(req1_ready), 128'(eg_v && eg_id));
    chk("busy", 128'(busy), 128'(mdl_busy));
    chk("core_start", 128'(core_start), 128'(mdl_busy && cyc == acc_cyc + 1));
    chk("core_data", core_data, mdl_core_data);
    chk("core_key", core_key, mdl_core_key);
    chk("rsp_valid", 128'(rsp_valid), 128'(exp_rv));
    chk("rsp_data", rsp_data, exp_rd);
    chk("rsp_id", 128'(rsp_id), 128'(mdl_rsp_id));
    chk("rsp_err", 128'(rsp_err), 128'(exp_re));
    if (req0_ready) grant_q.push_back(0);
    if (req1_ready) grant_q.push_back(1);
    if (rst) begin
      mdl_reset();
    end else if (eg_v) begin
      job_id = eg_id; job_data = eg_id ? d1 : d0; job_key = eg_id ? k1 : k0;
      acc_cyc = cyc; mdl_busy = 1;
      mdl_rsp_id = eg_id; mdl_core_data = job_data; mdl_core_key = job_key;
      if (core_lat >= 1 && core_lat <= TIMEOUT) begin
        resp_cyc = cyc + 2 + core_lat; job_err = 0; job_res = mix(job_data, job_key);
      end else begin
        resp_cyc = cyc + 2 + TIMEOUT; job_err = 1; job_res = '0;
      end
    end else if (exp_rv && rr) begin
      $display("rsp cyc=%0d id=%0d err=%0d data=%h", cyc, rsp_id, rsp_err, rsp_data);
      rspid_q.push_back(int'(rsp_id));
      mdl_busy = 0; mdl_last = job_id; mdl_rsp_data = job_res; mdl_rsp_err = job_err;
    end
    @(posedge clk);
    #1;
    cyc++;
    core_done = 0;
    core_result = rnd128();
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin core_done = 1; core_result = mix(cm_d, cm_k); end
    end
    if (core_start) begin cm_d = core_data; cm_k = core_key; core_cnt = core_lat; end
    if (!core_done && !mdl_busy && (stray_once || (stray_en && $urandom_range(0, 3) == 0))) begin
      core_done = 1; stray_once = 0;
    end
  endtask

  task automatic wait_rsp(input int acc, input int lat, input string tag);
    for (int n = 0; n < 60 && !rsp_valid; n++) run_cycle(0, 0, 0, 0);
    chk(tag, 128'(cyc - acc), 128'(lat));
  endtask

  task automatic drain();
    for (int n = 0; n < 80 && (busy || mdl_busy); n++) run_cycle(0, 0, 1, 0);
    chk("drain_busy", 128'(busy), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    reset = 1; req0_valid = 0; req1_valid = 0; rsp_ready = 0; core_done = 0; core_result = '0;
    req0_data = '0; req0_key = '0; req1_data = '0; req1_key = '0;
    d0 = rnd128(); k0 = rnd128(); d1 = rnd128(); k1 = rnd128();
    core_lat = 11; core_cnt = 0; stray_en = 0; stray_once = 0;
    acc_cyc = -10; resp_cyc = 0; job_id = 0; job_err = 0; job_data = '0; job_key = '0; job_res = '0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    run_cycle(0, 0, 1, 1);
    run_cycle(0, 0, 1, 0);

    // single known-answer job
    d0 = KAT_PT; k0 = KAT_KEY; core_lat = 11; a = cyc;
    run_cycle(1, 0, 1, 0);
    wait_rsp(a, 13, "kat_latency");
    chk("kat_data", rsp_data, KAT_CT);
    chk("kat_id", 128'(rsp_id), 128'd0);
    chk("kat_err", 128'(rsp_err), 128'd0);
    run_cycle(0, 0, 1, 0);
    drain();

    // contention from reset
    run_cycle(0, 0, 1, 1);
    grant_q.delete(); rspid_q.delete();
    for (int n = 0; n < 200 && rspid_q.size() < 4; n++) begin
      d0 = rnd128(); k0 = rnd128(); d1 = rnd128(); k1 = rnd128();
      run_cycle(1, 1, 1, 0);
    end
    chk("cont_count", 128'(rspid_q.size() >= 4 && grant_q.size() >= 4), 128'd1);
    for (int i = 0; i < 4; i++) begin
      chk("cont_grant", 128'(grant_q[i]), 128'(i % 2));
      chk("cont_rsp_id", 128'(rspid_q[i]), 128'(i % 2));
    end
    drain();

    // backpressure
    d1 = rnd128(); k1 = rnd128(); core_lat = 11;
    run_cycle(0, 1, 0, 0);
    for (int n = 0; n < 40 && !rsp_valid; n++) run_cycle(0, 0, 0, 0);
    for (int n = 0; n < 20; n++) run_cycle(1, 1, 0, 0);
    run_cycle(1, 1, 1, 0);
    run_cycle(1, 1, 1, 0);
    drain();

    // timeout, then a stray done while idle
    d0 = rnd128(); k0 = rnd128(); core_lat = 0; a = cyc;
    run_cycle(1, 0, 1, 0);
    wait_rsp(a, TIMEOUT + 2, "to_latency");
    chk("to_err", 128'(rsp_err), 128'd1);
    chk("to_data", rsp_data, 128'd0);
    run_cycle(0, 0, 1, 0);
    stray_once = 1;
    for (int n = 0; n < 4; n++) run_cycle(0, 0, 1, 0);
    chk("stray_busy", 128'(busy), 128'd0);

    // done on the final timer tick
    d0 = rnd128(); k0 = rnd128(); core_lat = TIMEOUT; a = cyc;
    run_cycle(1, 0, 1, 0);
    wait_rsp(a, TIMEOUT + 2, "coin_latency");
    chk("coin_err", 128'(rsp_err), 128'd0);
    chk("coin_data", rsp_data, mix(d0, k0));
    run_cycle(0, 0, 1, 0);
    drain();

    // reset while waiting on the core
    d1 = rnd128(); k1 = rnd128(); core_lat = 11;
    run_cycle(0, 1, 1, 0);
    for (int n = 0; n < 5; n++) run_cycle(0, 0, 1, 0);
    run_cycle(1, 1, 1, 1);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_core_data", core_data, 128'd0);
    grant_q.delete();
    run_cycle(1, 1, 1, 0);
    chk("rst_first_grant", 128'(grant_q.size() == 1 && grant_q[0] == 0), 128'd1);
    drain();

    // random traffic
    stray_en = 1;
    for (int n = 0; n < 1500; n++) begin
      if (!mdl_busy) begin
        case ($urandom_range(0, 5))
          0: core_lat = 0;
          1: core_lat = 1;
          2: core_lat = TIMEOUT;
          3: core_lat = TIMEOUT + 1;
          default: core_lat = $urandom_range(1, 20);
        endcase
      end
      d0 = rnd128(); k0 = rnd128(); d1 = rnd128(); k1 = rnd128();
      run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 2) != 0), $urandom_range(0, 199) == 0);
    end
    stray_en = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_req_scheduler.md
# aes_req_scheduler

Round-robin scheduler that shares one iterative AES-128 encryption core between two requesters. Each requester hands over a plaintext/key pair with a valid/ready handshake. The scheduler launches the core and waits for its done pulse, then returns the ciphertext tagged with the requester ID. A watchdog timeout flags a core that never completes, so a requester is never left hung.

## Interface
Parameters:
- TIMEOUT, 16: cycles allowed in WAIT before error; legal range 2..255. The core nominally needs 11 cycles.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a job
- req0_ready  out  1  scheduler accepts requester 0 this cycle
- req0_data  in  128  requester 0 plaintext
- req0_key  in  128  requester 0 cipher key
- req1_valid, req1_ready, req1_data, req1_key: same as requester 0, for requester 1
- core_start  out  1  one-cycle launch pulse to the AES core
- core_data  out  128  plaintext to core; held stable from launch until the job ends
- core_key  out  128  key to core; held stable from launch until the job ends
- core_done  in  1  one-cycle pulse; core_result valid in the same cycle
- core_result  in  128  ciphertext from core
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  128  ciphertext, or 0 on error
- rsp_id  out  1  ID of the requester that owns the response
- rsp_err  out  1  1 means the core timed out
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- **IDLE**
  - Arbitrate between requesters; req_ready is combinational from the valid inputs and last_grant.
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester that is not last_grant is granted.
  - Only the granted requester sees req_ready=1. Both readys are 0 in all other states.
  - When valid&&ready: register data into core_data, key into core_key, and the ID into rsp_id. Go to LAUNCH.
- **LAUNCH**
  - core_start=1 for exactly this cycle.
  - Clear the timer. Go to WAIT.
- **WAIT**
  - Timer increments by 1 each cycle; it is 8 bits wide.
  - If core_done=1: rsp_data<=core_result, rsp_err<=0, go to RESP.
  - Else if timer==TIMEOUT-1: rsp_data<=0, rsp_err<=1, go to RESP.
  - If core_done and the timeout occur in the same cycle, core_done wins and rsp_err=0.
- **RESP**
  - rsp_valid=1; rsp_data, rsp_id and rsp_err are held stable while rsp_ready=0.
  - On rsp_valid&&rsp_ready: last_grant<=rsp_id, go to IDLE.
- core_done outside WAIT (stale, or a late pulse after a timeout) is ignored.
- A late core_done after a timeout must not corrupt the following job's WAIT. The following job's core_start re-launches the core.
- The scheduler holds no more than one job at a time. A requester whose valid drops before the grant loses nothing.

## Timing
- **Reset values** (reset=1 on a rising edge):
  - state=IDLE, last_grant=1 (so requester 0 wins the first contention).
  - core_start=0, core_data=0, core_key=0.
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0, timer=0.
  - req_ready outputs are 0 during the reset cycle.
- **Latency**
  - Accept in cycle T; core_start in T+1.
  - A core_done in cycle T+1+L gives rsp_valid in T+2+L.
  - With L=11: 13 cycles from accept to response, when the consumer is ready.
- **Throughput**
  - A response handshake in cycle R allows the earliest next accept in R+1.
  - With rsp_ready tied high, the minimum job spacing is L+3 cycles.
- **Timeout**: a launch in T+1 with no done gives rsp_valid, rsp_err=1 in cycle T+2+TIMEOUT.
- **Reset mid-operation**
  - Reset in any state returns to IDLE next cycle with all reset values.
  - The in-flight job is dropped with no response, and no core_start is issued.
- A requester asserting valid during RESP or WAIT waits; it keeps its place and is arbitrated on return to IDLE.

## Test plan
- **Single job**
  - Stimulus: req0 with data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f; core model with 11-cycle latency.
  - Required: rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id=0, rsp_err=0, rsp_valid 13 cycles after accept.
  - Also check: core_data and core_key stay stable through WAIT.
- **Contention**
  - Stimulus: req0 and req1 held valid continuously from reset.
  - Required: grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; no double accept.
- **Backpressure**
  - Stimulus: rsp_ready=0 for 20 cycles after rsp_valid.
  - Required: response fields stay constant, both req_ready stay 0, busy=1; on release, handshake in 1 cycle and the next grant follows.
- **Timeout**
  - Stimulus: TIMEOUT=16 and the core never asserts done.
  - Required: rsp_err=1, rsp_data=0, rsp_valid exactly 18 cycles after accept.
  - Follow-up: a stray core_done in IDLE is ignored.
- **Coincidence**
  - Stimulus: core_done arrives in the same cycle as timer==TIMEOUT-1.
  - Required: rsp_err=0, rsp_data=core_result.
- **Reset mid-job**
  - Stimulus: reset asserted during WAIT.
  - Required: next cycle state is IDLE with all outputs at reset values and no response emitted; the subsequent job completes normally with requester 0 winning contention.
